fifo_wptr_full: RTL and testbench

- Write-domain pointer and full-flag controller for the async FIFO.
- Sits directly upstream of the dual-port FIFO memory and drives its w_Addr, w_Enable and fifo_Full inputs.
- Synchronizes the read-domain Gray pointer into w_Clk and keeps the binary/Gray write pointer.
- Generates registered full, almost-full and fill-level flags.

---
 rtl/fifo_wptr_full.sv | 107 ++++++++++
 tb/tb_fifo_wptr_full.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wptr_full.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wptr_full
//  Purpose  : Write-side pointer and full-flag controller of an asynchronous
//             FIFO. Keeps the binary/Gray write pointer and brings the
//             read-domain Gray pointer into the write clock domain through
//             two flops. It produces registered full, almost-full and
//             fill-level flags.
//  Ports    :
//     w_Clk        in   1     write clock, rising edge
//     w_Rst_n      in   1     asynchronous active-low reset
//     w_Inc        in   1     write request from the producer
//     r_Ptr_gray   in   AS+1  read pointer (Gray), asynchronous to w_Clk
//     w_Enable     out  1     memory write strobe (w_Inc && !fifo_Full)
//     w_Addr       out  AS    memory write address
//     w_Ptr_gray   out  AS+1  registered Gray write pointer to read domain
//     fifo_Full    out  1     registered full flag
//     almost_Full  out  1     registered almost-full flag
//     w_Level      out  AS+1  registered fill level, 0..depth
//  Revision : 1.0  initial release
// ============================================================================
module fifo_wptr_full #(
   parameter int address_Size = 5,
   parameter int af_Margin    = 4
) (
   input  logic                    w_Clk,
   input  logic                    w_Rst_n,
   input  logic                    w_Inc,
   input  logic [address_Size:0]   r_Ptr_gray,
   output logic                    w_Enable,
   output logic [address_Size-1:0] w_Addr,
   output logic [address_Size:0]   w_Ptr_gray,
   output logic                    fifo_Full,
   output logic                    almost_Full,
   output logic [address_Size:0]   w_Level
);

   localparam int            PTR_W     = address_Size + 1;
   localparam int            DEPTH     = 1 << address_Size;
   localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - af_Margin);

   logic [PTR_W-1:0] w_bin;
   logic [PTR_W-1:0] w_bin_next;
   logic [PTR_W-1:0] w_gray_next;
   logic [PTR_W-1:0] rq1;
   logic [PTR_W-1:0] rq2;
   logic [PTR_W-1:0] r_bin_sync;
   logic [PTR_W-1:0] level_next;
   logic             accept;
   logic             full_next;
   logic             af_next;

   // A write is taken only while not full; requests while full are dropped.
   always_comb begin
      accept = w_Inc & ~fifo_Full;
   end

   assign w_Enable = accept;
   assign w_Addr   = w_bin[address_Size-1:0];

   // Next pointer in binary and Gray. The extra MSB lets full and empty be
   // told apart across the wrap without any special-case logic.
   always_comb begin
      w_bin_next  = w_bin + {{address_Size{1'b0}}, accept};
      w_gray_next = (w_bin_next >> 1) ^ w_bin_next;
   end

   // Gray-to-binary of the synchronized read pointer: bit i is the XOR of
   // all Gray bits from the MSB down to i.
   always_comb begin
      r_bin_sync = '0;
      for (int i = 0; i < PTR_W; i++) begin
         r_bin_sync[i] = ^(rq2 >> i);
      end
   end

   // Full when the next write pointer equals the read pointer with its two
   // top Gray bits inverted, i.e. exactly one full lap ahead.
   always_comb begin
      full_next  = (w_gray_next == {~rq2[PTR_W-1:PTR_W-2], rq2[PTR_W-3:0]});
      level_next = w_bin_next - r_bin_sync;
      af_next    = (level_next >= AF_THRESH);
   end

   always_ff @(posedge w_Clk or negedge w_Rst_n) begin
      if (!w_Rst_n) begin
         w_bin       <= '0;
         w_Ptr_gray  <= '0;
         rq1         <= '0;
         rq2         <= '0;
         fifo_Full   <= 1'b0;
         almost_Full <= 1'b0;
         w_Level     <= '0;
      end else begin
         // Plain two-flop synchronizer; only rq2 is ever consumed.
         rq1         <= r_Ptr_gray;
         rq2         <= rq1;
         w_bin       <= w_bin_next;
         w_Ptr_gray  <= w_gray_next;
         fifo_Full   <= full_next;
         almost_Full <= af_next;
         w_Level     <= level_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wptr_full.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wptr_full
//  Purpose  : Self-checking bench for fifo_wptr_full. Stimulus pushes the
//             expected output set for each cycle into a scoreboard queue;
//             a monitor pops and compares once per cycle. Directed checks
//             cover full/almost-full thresholds, read-pointer latency,
//             simultaneous events, wrap-around and asynchronous reset.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_wptr_full;

   localparam int AS = 5;
   localparam int PW = AS + 1;

   logic          w_Clk = 1'b0;
   logic          w_Rst_n = 1'b0;
   logic          w_Inc = 1'b0;
   logic [PW-1:0] r_Ptr_gray = '0;
   logic          w_Enable;
   logic [AS-1:0] w_Addr;
   logic [PW-1:0] w_Ptr_gray;
   logic          fifo_Full;
   logic          almost_Full;
   logic [PW-1:0] w_Level;

   fifo_wptr_full #(.address_Size(AS), .af_Margin(4)) dut (
      .w_Clk       (w_Clk),
      .w_Rst_n     (w_Rst_n),
      .w_Inc       (w_Inc),
      .r_Ptr_gray  (r_Ptr_gray),
      .w_Enable    (w_Enable),
      .w_Addr      (w_Addr),
      .w_Ptr_gray  (w_Ptr_gray),
      .fifo_Full   (fifo_Full),
      .almost_Full (almost_Full),
      .w_Level     (w_Level)
   );

   always #5 w_Clk = ~w_Clk;

   typedef struct {
      logic          wen;
      logic [AS-1:0] addr;
      logic [PW-1:0] gray;
      logic          full;
      logic          af;
      logic [PW-1:0] level;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: write count, read pointer seen through a two-stage
   // delay, and the flags derived from the outstanding-word count.
   int   m_wbin = 0;
   int   m_rq1  = 0;
   int   m_rq2  = 0;
   int   m_level = 0;
   bit   m_full = 1'b0;
   bit   m_af   = 1'b0;

   bit            prev_ok = 1'b0;
   logic [PW-1:0] prev_gray;
   logic          prev_wen;

   function automatic logic [PW-1:0] bin2gray(input int b);
      logic [PW-1:0] v;
      v = PW'(b);
      return v ^ (v >> 1);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_addr"},  int'(w_Addr), 0);
      check({tag, "_gray"},  int'(w_Ptr_gray), 0);
      check({tag, "_full"},  int'(fifo_Full), 0);
      check({tag, "_af"},    int'(almost_Full), 0);
      check({tag, "_level"}, int'(w_Level), 0);
   endtask

   task automatic model_reset();
      m_wbin = 0; m_rq1 = 0; m_rq2 = 0; m_level = 0;
      m_full = 1'b0; m_af = 1'b0;
   endtask

   task automatic model_edge(input bit inc, input int rbin);
      int acc;
      acc     = (inc && !m_full) ? 1 : 0;
      m_wbin  = (m_wbin + acc) % 64;
      m_level = (m_wbin - m_rq2 + 64) % 64;
      m_full  = (m_level == 32);
      m_af    = (m_level >= 28);
      m_rq2   = m_rq1;
      m_rq1   = rbin % 64;
   endtask

   // One write-clock cycle: drive inputs on the falling edge, queue what the
   // outputs must show during this cycle, then advance the model on the
   // rising edge.
   task automatic step(input bit inc, input int rbin);
      exp_t e;
      @(negedge w_Clk);
      w_Inc      = inc;
      r_Ptr_gray = bin2gray(rbin);
      e.wen   = inc && !m_full;
      e.addr  = AS'(m_wbin % 32);
      e.gray  = bin2gray(m_wbin);
      e.full  = m_full;
      e.af    = m_af;
      e.level = PW'(m_level);
      sb_q.push_back(e);
      @(posedge w_Clk);
      model_edge(inc, rbin);
   endtask

   task automatic pulse_reset(input string tag);
      @(negedge w_Clk);
      w_Inc      = 1'b0;
      r_Ptr_gray = '0;
      #2 w_Rst_n = 1'b0;
      #1 check_zero(tag);
      #1 w_Rst_n = 1'b1;
      model_reset();
      prev_ok = 1'b0;
      @(posedge w_Clk);
   endtask

   // Monitor: compare the DUT against the queued expectation each cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge w_Clk);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_wen",   int'(w_Enable),    int'(e.wen));
            check("sb_addr",  int'(w_Addr),      int'(e.addr));
            check("sb_gray",  int'(w_Ptr_gray),  int'(e.gray));
            check("sb_full",  int'(fifo_Full),   int'(e.full));
            check("sb_af",    int'(almost_Full), int'(e.af));
            check("sb_level", int'(w_Level),     int'(e.level));
            if (prev_ok) begin
               check("gray_1bit", $countones(w_Ptr_gray ^ prev_gray),
                     prev_wen ? 1 : 0);
            end
            prev_gray = w_Ptr_gray;
            prev_wen  = w_Enable;
            prev_ok   = 1'b1;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int af_at;
      int full_at;
      int full_seen;
      int guard;

      // Reset state
      #3 check_zero("reset");
      #5 w_Rst_n = 1'b1;
      @(posedge w_Clk);

      // Idle
      for (int k = 0; k < 10; k++) step(1'b0, 0);
      #1 check_zero("idle");

      // Fill: 40 requests with the reader parked at 0
      af_at = 0;
      full_at = 0;
      for (int k = 1; k <= 40; k++) begin
         step(1'b1, 0);
         #1;
         if (af_at == 0 && almost_Full) af_at = k;
         if (full_at == 0 && fifo_Full) full_at = k;
         if (k == 32) begin
            check("full_gray32", int'(w_Ptr_gray), 48);
            check("full_addr32", int'(w_Addr), 0);
         end
      end
      check("af_rise_accept", af_at, 28);
      check("full_rise_accept", full_at, 32);
      check("full_hold_level", int'(w_Level), 32);
      check("full_hold_gray", int'(w_Ptr_gray), 48);

      // Reader advances to 1: full must fall on the third edge
      for (int k = 1; k <= 3; k++) begin
         step(1'b0, 1);
         #1;
         if (k < 3) check("full_lat_hold", int'(fifo_Full), 1);
         else begin
            check("full_lat_fall", int'(fifo_Full), 0);
            check("full_lat_level", int'(w_Level), 31);
         end
      end
      step(1'b1, 1);
      #1;
      check("refill_addr", int'(w_Addr), 1);
      check("refill_full", int'(fifo_Full), 1);

      // Bring level to 31, then write on the edge that sees the read advance
      for (int k = 0; k < 3; k++) step(1'b0, 2);
      #1 check("pre_sim_level", int'(w_Level), 31);
      step(1'b0, 3);
      step(1'b0, 3);
      step(1'b1, 3);
      #1;
      check("sim_level", int'(w_Level), 31);
      check("sim_full", int'(fifo_Full), 0);
      check("sim_addr", int'(w_Addr), 2);

      // Drain, then 100 writes with the reader 4 behind, crossing the wrap
      for (int k = 0; k < 3; k++) step(1'b0, 34);
      #1 check("drain_level", int'(w_Level), 0);
      full_seen = 0;
      for (int i = 0; i < 100; i++) begin
         step(1'b1, 34 + ((i >= 4) ? i - 4 : 0));
         #1;
         if (fifo_Full) full_seen++;
      end
      check("wrap_full_seen", full_seen, 0);
      check("wrap_gray", int'(w_Ptr_gray), 5);
      check("wrap_level", int'(w_Level), 7);

      // Reset mid-operation
      for (int k = 0; k < 20; k++) step(1'b1, 129);
      pulse_reset("midrst");
      step(1'b1, 0);
      #1;
      check("resume_addr", int'(w_Addr), 1);
      check("resume_level", int'(w_Level), 1);
      for (int k = 0; k < 3; k++) step(1'b0, 0);

      guard = 0;
      while (sb_q.size() > 0 && guard < 10) begin
         @(negedge w_Clk);
         #2;
         guard++;
      end
      check("sb_drain", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
